// File: rtl/sprite_line_scheduler.sv
// Per-line sprite scheduler: scans the sprite bank in blanking,
// captures intersecting sprites and feeds them to the line counter.
module sprite_line_scheduler #(
  parameter int NUM_SPRITES = 32,
  parameter int MAX_ACTIVE  = 4,
  parameter int SPRITE_SIZE = 20,
  parameter int size_x      = 10,
  parameter int size_y      = 9
) (
  input  logic                           clk_pixel,
  input  logic                           reset,
  input  logic                           new_line,
  input  logic [size_y-1:0]              line_y,
  input  logic [size_x-1:0]              pixel_x,
  output logic [$clog2(NUM_SPRITES)-1:0] reg_address,
  input  logic [31:0]                    reg_data,
  input  logic                           count_finished,
  output logic                           sprite_on,
  output logic [31:0]                    sprite_datas,
  output logic                           scan_done,
  output logic                           overflow
);

  localparam int AW = $clog2(NUM_SPRITES);
  localparam int CW = $clog2(MAX_ACTIVE + 1);
  localparam int IW = $clog2(MAX_ACTIVE);
  localparam int SW = AW + 1;
  localparam int DW = $clog2(SPRITE_SIZE + 2);
  localparam int XW = size_x + 1;
  localparam int YW = size_y + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] READY = 2'd2;
  localparam logic [1:0] DRAW  = 2'd3;

  localparam logic [CW-1:0] FULL = CW'(MAX_ACTIVE);
  localparam logic [CW-1:0] C1   = CW'(1);
  localparam logic [SW-1:0] LAST = SW'(NUM_SPRITES);
  localparam logic [SW-1:0] S1   = SW'(1);
  localparam logic [AW-1:0] A1   = AW'(1);
  localparam logic [DW-1:0] TMO  = DW'(SPRITE_SIZE + 1);
  localparam logic [DW-1:0] D1   = DW'(1);
  localparam logic [YW-1:0] SZY  = YW'(SPRITE_SIZE);
  localparam logic [8:0]    SZ9  = 9'(SPRITE_SIZE);
  localparam logic [XW-1:0] X1   = XW'(1);

  logic [1:0]    state;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] draw_cnt;
  logic [CW-1:0] cnt;
  logic [31:0]   list [MAX_ACTIVE];

  logic [YW-1:0] ly;
  logic [YW-1:0] wy;
  logic          hit;
  logic [8:0]    row_off;
  logic [31:0]   adj;

  // Match test and row-offset rewrite for the word on reg_data
  always_comb begin
    ly      = YW'(line_y);
    wy      = YW'(reg_data[17:9]);
    hit     = reg_data[28] && (reg_data[26:18] != 9'd0)
              && (ly >= wy) && (ly < wy + SZY);
    row_off = reg_data[8:0]
              + (9'(line_y) - reg_data[17:9]) * SZ9;
    adj     = {reg_data[31:9], row_off};
  end

  logic [XW-1:0] hx;
  logic [XW-1:0] px;
  logic          missed;
  logic          fire;
  logic          draw_exit;
  logic          pop;

  // Head-of-list timing decisions
  always_comb begin
    hx        = XW'(list[0][26:18]);
    px        = XW'(pixel_x);
    missed    = hx <= px;
    fire      = (px + X1) == hx;
    draw_exit = ((draw_cnt != '0) && count_finished)
                || (draw_cnt == TMO);
    pop       = ((state == READY) && (cnt != '0) && missed)
                || ((state == DRAW) && draw_exit);
  end

  // Scheduler state, capture list and registered outputs
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      scan_cnt     <= '0;
      draw_cnt     <= '0;
      cnt          <= '0;
      reg_address  <= '0;
      sprite_on    <= 1'b0;
      sprite_datas <= '0;
      scan_done    <= 1'b0;
      overflow     <= 1'b0;
      for (int i = 0; i < MAX_ACTIVE; i++) list[i] <= '0;
    end else if (new_line) begin
      state       <= SCAN;
      scan_cnt    <= '0;
      draw_cnt    <= '0;
      cnt         <= '0;
      reg_address <= '0;
      sprite_on   <= 1'b0;
      scan_done   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: reg_address <= '0;
        SCAN: begin
          scan_cnt    <= scan_cnt + S1;
          reg_address <= reg_address + A1;
          if ((scan_cnt != '0) && hit) begin
            if (cnt == FULL) begin
              overflow <= 1'b1;
            end else begin
              list[cnt[IW-1:0]] <= adj;
              cnt <= cnt + C1;
            end
          end
          if (scan_cnt == LAST) begin
            state       <= READY;
            scan_done   <= 1'b1;
            reg_address <= '0;
          end
        end
        READY: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else if (missed) begin
            cnt <= cnt - C1;
          end else if (fire) begin
            sprite_datas <= list[0];
            sprite_on    <= 1'b1;
            draw_cnt     <= '0;
            state        <= DRAW;
          end
        end
        DRAW: begin
          if (draw_exit) begin
            sprite_on <= 1'b0;
            cnt       <= cnt - C1;
            state     <= READY;
          end else begin
            draw_cnt <= draw_cnt + D1;
          end
        end
      endcase
      if (pop) begin
        for (int i = 0; i < MAX_ACTIVE - 1; i++) list[i] <= list[i+1];
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Bench for sprite_line_scheduler: directed line scenarios plus
// randomized sprite banks against a line-level reference model.
module tb_sprite_line_scheduler;

  localparam int NS = 32;
  localparam int MA = 4;
  localparam int SZ = 20;
  localparam int LINE_CYC = 600;

  logic        clk_pixel = 1'b0;
  logic        reset = 1'b1;
  logic        new_line = 1'b0;
  logic        count_finished = 1'b0;
  logic [8:0]  line_y = '0;
  logic [9:0]  pixel_x = '0;
  logic [4:0]  reg_address;
  logic [31:0] reg_data = '0;
  logic        sprite_on;
  logic [31:0] sprite_datas;
  logic        scan_done;
  logic        overflow;

  logic [31:0] bank [NS];
  int n_chk = 0;
  int n_fail = 0;

  int          obs_px [$];
  logic [31:0] obs_w [$];
  int          obs_len [$];

  sprite_line_scheduler dut (
    .clk_pixel      (clk_pixel),
    .reset          (reset),
    .new_line       (new_line),
    .line_y         (line_y),
    .pixel_x        (pixel_x),
    .reg_address    (reg_address),
    .reg_data       (reg_data),
    .count_finished (count_finished),
    .sprite_on      (sprite_on),
    .sprite_datas   (sprite_datas),
    .scan_done      (scan_done),
    .overflow       (overflow)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Register bank with one cycle of read latency
  always @(posedge clk_pixel) reg_data <= bank[reg_address];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkw(input int vis, input int x,
                                      input int y, input int off);
    logic [31:0] w;
    w = '0;
    w[28] = vis[0];
    w[26:18] = x[8:0];
    w[17:9] = y[8:0];
    w[8:0] = off[8:0];
    return w;
  endfunction

  task automatic clear_bank();
    for (int i = 0; i < NS; i++) bank[i] = '0;
  endtask

  // mode 0: downstream finishes after SZ pixels
  // mode 1: count_finished held 1, mode 2: held 0
  // stop_k > 0: abandon at cycle stop_k; -1: abandon at first draw
  task automatic run_line(input int ly, input int h, input int mode,
                          input int stop_k);
    logic [31:0] cap [$];
    int exp_px [$];
    logic [31:0] exp_w [$];
    int ov_at;
    int pxm;
    int d;
    int run_len;
    bit so_prev;
    bit cf_pulse;
    bit stopped;
    ov_at = -1;
    run_len = 0;
    so_prev = 0;
    cf_pulse = 0;
    stopped = 0;
    for (int i = 0; i < NS; i++) begin
      int x, y, off;
      x = int'(bank[i][26:18]);
      y = int'(bank[i][17:9]);
      off = int'(bank[i][8:0]);
      if (bank[i][28] && x != 0 && y <= ly && ly < y + SZ) begin
        if (cap.size() < MA)
          cap.push_back({bank[i][31:9], 9'((off + (ly - y) * SZ) % 512)});
        else if (ov_at < 0)
          ov_at = i;
      end
    end
    d = (mode == 1) ? 2 : (mode == 2) ? SZ + 2 : SZ;
    pxm = h;
    foreach (cap[i]) begin
      int x;
      x = int'(cap[i][26:18]);
      if (x <= pxm) pxm++;
      else begin
        exp_px.push_back(x);
        exp_w.push_back(cap[i]);
        pxm = x + d;
      end
    end
    obs_px.delete();
    obs_w.delete();
    obs_len.delete();
    line_y = 9'(ly);
    pixel_x = 10'(h);
    count_finished = (mode == 1);
    new_line = 1'b1;
    @(negedge clk_pixel);
    new_line = 1'b0;
    for (int k = 0; k < LINE_CYC; k++) begin
      if (k > 0) @(negedge clk_pixel);
      pixel_x = 10'((k <= NS + 1) ? h : h + k - (NS + 1));
      chk("scan_done", 32'(scan_done), 32'(k >= NS + 1));
      chk("overflow", 32'(overflow), 32'(ov_at >= 0 && k >= ov_at + 2));
      if (k < NS) chk("reg_address", 32'(reg_address), 32'(k));
      if (k == 0) chk("on_after_new_line", 32'(sprite_on), 32'(0));
      if (cf_pulse) chk("fall_after_finish", 32'(sprite_on), 32'(0));
      if (sprite_on && !so_prev) begin
        obs_px.push_back(int'(pixel_x));
        obs_w.push_back(sprite_datas);
        run_len = 1;
      end else if (sprite_on) begin
        run_len++;
      end else if (so_prev) begin
        obs_len.push_back(run_len);
      end
      so_prev = sprite_on;
      cf_pulse = (mode == 0) && sprite_on && (run_len == SZ);
      if (mode == 0) count_finished = cf_pulse;
      if ((stop_k > 0 && k == stop_k) || (stop_k < 0 && obs_px.size() > 0)) begin
        stopped = 1;
        break;
      end
    end
    if (!stopped) begin
      chk("rise_count", 32'(obs_px.size()), 32'(exp_px.size()));
      chk("fall_count", 32'(obs_len.size()), 32'(exp_px.size()));
      foreach (exp_px[i]) begin
        if (i < obs_px.size()) begin
          chk("rise_px", 32'(obs_px[i]), 32'(exp_px[i]));
          chk("rise_word", obs_w[i], exp_w[i]);
        end
        if (i < obs_len.size()) chk("on_len", 32'(obs_len[i]), 32'(d));
      end
    end
  endtask

  task automatic reset_mid();
    #1 reset = 1'b1;
    #1;
    chk("rst_sprite_on", 32'(sprite_on), 32'(0));
    chk("rst_sprite_datas", sprite_datas, 32'(0));
    chk("rst_reg_address", 32'(reg_address), 32'(0));
    chk("rst_scan_done", 32'(scan_done), 32'(0));
    chk("rst_overflow", 32'(overflow), 32'(0));
    count_finished = 1'b0;
    @(negedge clk_pixel);
    reset = 1'b0;
  endtask

  initial begin
    int ly;
    int idx [6];
    clear_bank();
    repeat (2) @(negedge clk_pixel);
    chk("reset_sprite_on", 32'(sprite_on), 32'(0));
    chk("reset_sprite_datas", sprite_datas, 32'(0));
    chk("reset_reg_address", 32'(reg_address), 32'(0));
    chk("reset_scan_done", 32'(scan_done), 32'(0));
    chk("reset_overflow", 32'(overflow), 32'(0));
    reset = 1'b0;
    @(negedge clk_pixel);

    bank[3] = mkw(1, 100, 50, 0);
    run_line(53, 0, 0, 0);
    if (obs_px.size() > 0) begin
      chk("single_px", 32'(obs_px[0]), 32'(100));
      chk("single_off", 32'(obs_w[0][8:0]), 32'(60));
    end

    clear_bank();
    bank[7] = mkw(1, 200, 50, 0);
    run_line(69, 0, 0, 0);
    if (obs_w.size() > 0) chk("row_last_off", 32'(obs_w[0][8:0]), 32'(380));
    run_line(70, 0, 0, 0);
    chk("row_past_end", 32'(obs_px.size()), 32'(0));
    bank[7] = mkw(1, 200, 500, 0);
    run_line(5, 0, 0, 0);
    chk("no_wrap", 32'(obs_px.size()), 32'(0));

    clear_bank();
    idx = '{2, 5, 9, 11, 20, 30};
    for (int i = 0; i < 6; i++) bank[idx[i]] = mkw(1, 10 + 30 * i, 97, i);
    run_line(100, 0, 0, 0);
    chk("ovf_drawn", 32'(obs_px.size()), 32'(4));
    chk("ovf_sticky", 32'(overflow), 32'(1));

    clear_bank();
    bank[0] = mkw(1, 0, 60, 0);
    bank[1] = mkw(1, 30, 60, 0);
    run_line(62, 35, 0, 0);
    chk("missed_none", 32'(obs_px.size()), 32'(0));

    clear_bank();
    bank[4] = mkw(1, 150, 40, 5);
    run_line(45, 0, 1, 0);
    if (obs_len.size() > 0) chk("stale_len", 32'(obs_len[0]), 32'(2));
    run_line(45, 0, 2, 0);
    if (obs_len.size() > 0) chk("timeout_len", 32'(obs_len[0]), 32'(22));

    run_line(45, 0, 0, -1);
    count_finished = 1'b0;
    new_line = 1'b1;
    @(negedge clk_pixel);
    new_line = 1'b0;
    chk("nl_draw_on", 32'(sprite_on), 32'(0));
    chk("nl_draw_addr0", 32'(reg_address), 32'(0));
    @(negedge clk_pixel);
    chk("nl_draw_addr1", 32'(reg_address), 32'(1));

    run_line(45, 0, 0, -1);
    reset_mid();
    run_line(45, 0, 0, 10);
    reset_mid();
    run_line(45, 0, 0, 0);

    for (int t = 0; t < 24; t++) begin
      ly = int'($urandom_range(0, 511));
      for (int i = 0; i < NS; i++) begin
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 5) == 0)
          w[17:9] = 9'((ly - int'($urandom_range(0, 24))) & 511);
        w[28] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) w[26:18] = '0;
        bank[i] = w;
      end
      run_line(ly, int'($urandom_range(0, 100)),
               int'($urandom_range(0, 2)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_line_scheduler.md
# sprite_line_scheduler

Per-scan-line sprite scheduler sitting directly upstream of `sprite_line_counter`. During horizontal blanking it scans the sprite register bank, captures up to MAX_ACTIVE sprites that intersect the upcoming line, and rewrites each captured sprite's offset to point at the correct sprite row. During active video it presents the captured sprites one at a time on `sprite_on`/`sprite_datas`, timed so the downstream counter sees its first pixel exactly at the sprite's X. It advances to the next sprite on `count_finished`.

## Interface
- NUM_SPRITES, 32: sprite words in the register bank; `reg_address` width is log2(NUM_SPRITES).
- MAX_ACTIVE, 4: capture-list depth per line.
- SPRITE_SIZE, 20: sprite width and height in pixels; equals downstream `size_line`.
- size_x, 10: `pixel_x` width.
- size_y, 9: `line_y` width.

- clk_pixel  in  1  VGA pixel clock; all state changes on its rising edge.
- reset  in  1  one clock; reset is asynchronous and active-high.
- new_line  in  1  one-cycle pulse at start of horizontal blanking.
- line_y  in  size_y  line being prepared; stable from `new_line` to the end of that line.
- pixel_x  in  size_x  current horizontal pixel counter.
- reg_address  out  log2(NUM_SPRITES)  sprite bank read address.
- reg_data  in  32  sprite word; valid one cycle after `reg_address`.
- count_finished  in  1  downstream row-complete flag.
- sprite_on  out  1  a sprite row is being drawn.
- sprite_datas  out  32  sprite word with the adjusted offset.
- scan_done  out  1  capture list complete for this line.
- overflow  out  1  more than MAX_ACTIVE sprites matched this line (sticky until next `new_line`).

## Operation
- Sprite word fields:
  - [28] visible.
  - [26:18] X.
  - [17:9] Y.
  - [8:0] offset.
  - Other bits pass through unchanged.
- Match rule: visible=1, X≠0, and Y ≤ line_y < Y+SPRITE_SIZE. The comparison is computed in size_y+1 bits, so Y near 511 never wraps.
- Capture: a matched word is stored with [8:0] = (offset + (line_y−Y)·SPRITE_SIZE) mod 512.
  - Entries are stored in ascending sprite index.
  - Matches beyond MAX_ACTIVE set `overflow` and are discarded.
- States:
  - IDLE: `reg_address`=0. `new_line` → SCAN.
  - SCAN: `reg_address` steps 0..NUM_SPRITES−1, one per cycle. `reg_data` is evaluated one cycle later. After the last word is evaluated → READY, and `scan_done`=1.
  - READY: if the list is empty → IDLE.
    - If head X ≤ pixel_x (missed), pop the head and stay in READY.
    - If pixel_x+1 == head X, load `sprite_datas`=head, set `sprite_on`=1 → DRAW.
  - DRAW: `count_finished` is ignored in the first DRAW cycle, because a stale 1 may remain from the previous sprite.
    - From the second cycle on, `count_finished`=1 → `sprite_on`=0, pop the head → READY.
    - Timeout: after SPRITE_SIZE+2 DRAW cycles, force the same exit.
- `new_line` in any state: clear the list, clear `overflow` and `scan_done`, drop `sprite_on`, and go to SCAN on the next edge. It takes priority over every other transition.
- `sprite_datas` holds its last value while `sprite_on`=0.

## Timing
- Reset values: `sprite_on`=0, `sprite_datas`=0, `reg_address`=0, `scan_done`=0, `overflow`=0. State=IDLE; list empty.
- Outputs are registered; none are combinational from inputs.
- Scan latency: `scan_done` rises NUM_SPRITES+1 cycles after `new_line` (33 for the defaults). This must fit the 160-pixel blanking interval.
- `sprite_on` rises at the edge where pixel_x becomes head X. The downstream block therefore sees X on its first pixel.
- Back-to-back sprites:
  - Next head X ≥ previous X+SPRITE_SIZE+1: drawn normally.
  - Next head X ≤ pixel_x on return to READY: popped as missed.
- A full list with a further match raises `overflow` on the cycle that match is evaluated.
- Asynchronous reset mid-DRAW drops `sprite_on` immediately.

## Test plan
- Single sprite: word X=100, Y=50, offset=0, visible, line_y=53.
  - Expect `scan_done` 33 cycles after `new_line`.
  - Expect `sprite_on` rising when pixel_x=100 with `sprite_datas`[8:0]=60.
  - Expect `sprite_on` falling on the cycle after `count_finished` rises.
- Row boundaries: Y=50, line_y=69 → captured, offset=380. line_y=70 → not captured. Y=500, line_y=5 → not captured (no wrap).
- Overflow: 6 visible sprites on line_y with X=10,40,70,100,130,160. Expect only the first 4 drawn, in index order, and `overflow`=1 until the next `new_line`.
- Missed and X=0: list entries X=0 and X=30 with a scan ending while pixel_x=35. Expect X=0 never captured, X=30 popped, and `sprite_on` to stay 0.
- Stale finish and timeout: hold `count_finished`=1 constantly. Expect `sprite_on` high for exactly 2 cycles.
  - With `count_finished`=0 constantly, expect `sprite_on` to drop after 22 cycles.
- `new_line` mid-DRAW and async reset mid-SCAN: expect `sprite_on`=0 next edge and a fresh scan from address 0. On reset, expect all outputs 0 with no clock edge.
